cache_system_2way: RTL and testbench

CACHE_SYSTEM_2WAY -- requirements
Module: cache_system_2way

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_l2_direct.sv | 43 ++++
 rtl/cache_system_2way.sv | 117 +++++++++++
 tb/tb_cache_system_2way.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared geometry and backing-memory model for the two-level cache.
// Optional L2 level is enabled by defining CACHE_L2_EN.
package cache_pkg;
    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 32;
    localparam int L1_WAYS  = 2;
    localparam int L1_SETS  = 8;
    localparam int L1_IDX_W = $clog2(L1_SETS);
    localparam int L1_TAG_W = ADDR_W - L1_IDX_W;
    localparam int L2_LINES = 64;
    localparam int L2_IDX_W = $clog2(L2_LINES);
    localparam int L2_TAG_W = ADDR_W - L2_IDX_W;
    localparam int PAD_W    = DATA_W / 2 - ADDR_W;

    // Backing store: each word encodes its own address twice.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {{PAD_W{1'b0}}, a, {PAD_W{1'b0}}, a};
    endfunction
endpackage

// File: rtl/cache_l2_direct.sv
// Direct-mapped L2: combinational lookup of the current array state plus a
// write port that fills one line per cycle. Used when CACHE_L2_EN is defined.
module cache_l2_direct
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data
);
    logic [L2_LINES-1:0] valid_reg;
    logic [L2_TAG_W-1:0] tag_mem  [L2_LINES];
    logic [DATA_W-1:0]   data_mem [L2_LINES];

    logic [L2_IDX_W-1:0] lookup_idx;
    logic [L2_IDX_W-1:0] fill_idx;

    assign lookup_idx  = lookup_addr[L2_IDX_W-1:0];
    assign fill_idx    = fill_addr[L2_IDX_W-1:0];
    assign lookup_hit  = valid_reg[lookup_idx] &&
                         (tag_mem[lookup_idx] == lookup_addr[ADDR_W-1:L2_IDX_W]);
    assign lookup_data = data_mem[lookup_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (fill_en) begin
            valid_reg[fill_idx] <= 1'b1;
        end
    end

    // Tag/data storage is left unreset; validity alone gates a hit.
    always_ff @(posedge clk) begin
        if (fill_en && !rst) begin
            tag_mem[fill_idx]  <= fill_addr[ADDR_W-1:L2_IDX_W];
            data_mem[fill_idx] <= fill_data;
        end
    end
endmodule

// File: rtl/cache_system_2way.sv
// Two-way set-associative L1 with one-word lines in front of an optional
// direct-mapped L2 (CACHE_L2_EN) and a combinational backing memory.
module cache_system_2way
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              read,
    output logic [DATA_W-1:0] read_data,
    output logic              l1_hit,
    output logic              l2_hit
);
    logic [L1_IDX_W-1:0] idx;
    logic [L1_TAG_W-1:0] tag;
    logic [L1_WAYS-1:0]  way_hit;
    logic [L1_WAYS-1:0]  way_valid;
    logic [L1_WAYS-1:0]  fill_way;
    logic [DATA_W-1:0]   way_data [L1_WAYS];
    logic [L1_SETS-1:0]  lru_reg;
    logic                l1_miss;
    logic                hit_way;
    logic                victim_way;
    logic [DATA_W-1:0]   fill_data;
    logic                l2_lookup_hit;
    logic [DATA_W-1:0]   l2_lookup_data;

    assign idx     = addr[L1_IDX_W-1:0];
    assign tag     = addr[ADDR_W-1:L1_IDX_W];
    assign l1_miss = ~|way_hit;
    assign hit_way = way_hit[1];

`ifdef CACHE_L2_EN
    logic l2_fill_en;

    assign l2_fill_en = read && l1_miss && !l2_lookup_hit;

    cache_l2_direct u_l2 (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (addr),
        .lookup_hit  (l2_lookup_hit),
        .lookup_data (l2_lookup_data),
        .fill_en     (l2_fill_en),
        .fill_addr   (addr),
        .fill_data   (mem_word(addr))
    );
`else
    assign l2_lookup_hit  = 1'b0;
    assign l2_lookup_data = '0;
`endif

    assign fill_data = l2_lookup_hit ? l2_lookup_data : mem_word(addr);

    // Prefer an empty way (way 0 first) before evicting the LRU way.
    always_comb begin
        victim_way = lru_reg[idx];
        if (!way_valid[0]) begin
            victim_way = 1'b0;
        end else if (!way_valid[1]) begin
            victim_way = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < L1_WAYS; gi++) begin : g_way
            logic [L1_SETS-1:0]  valid_reg;
            logic [L1_TAG_W-1:0] tag_mem  [L1_SETS];
            logic [DATA_W-1:0]   data_mem [L1_SETS];

            assign way_valid[gi] = valid_reg[idx];
            assign way_hit[gi]   = valid_reg[idx] && (tag_mem[idx] == tag);
            assign way_data[gi]  = data_mem[idx];
            assign fill_way[gi]  = read && l1_miss && (victim_way == 1'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= '0;
                end else if (fill_way[gi]) begin
                    valid_reg[idx] <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (fill_way[gi] && !rst) begin
                    tag_mem[idx]  <= tag;
                    data_mem[idx] <= fill_data;
                end
            end
        end
    endgenerate

    // LRU bit names the way to evict next: the one not just touched.
    always_ff @(posedge clk) begin
        if (rst) begin
            lru_reg <= '0;
        end else if (read) begin
            lru_reg[idx] <= l1_miss ? ~victim_way : ~hit_way;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l1_hit    <= 1'b0;
            l2_hit    <= 1'b0;
            read_data <= '0;
        end else if (read) begin
            l1_hit    <= !l1_miss;
            l2_hit    <= l1_miss && l2_lookup_hit;
            read_data <= l1_miss ? fill_data : way_data[hit_way];
        end else begin
            l1_hit <= 1'b0;
            l2_hit <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cache_system_2way.sv
// Directed table-driven bench for cache_system_2way; expected L2 hits follow
// whether CACHE_L2_EN is defined for the build.
module tb_cache_system_2way;
    logic        clk;
    logic        rst;
    logic [10:0] addr;
    logic        read;
    logic [31:0] read_data;
    logic        l1_hit;
    logic        l2_hit;

    int checks = 0;
    int errors = 0;

`ifdef CACHE_L2_EN
    localparam bit L2_ON = 1'b1;
`else
    localparam bit L2_ON = 1'b0;
`endif

    cache_system_2way dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .read      (read),
        .read_data (read_data),
        .l1_hit    (l1_hit),
        .l2_hit    (l2_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        read;
        logic [10:0] addr;
        logic        exp_l1;
        logic        exp_l2;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic logic [31:0] ref_word(input logic [10:0] a);
        return {5'b0, a, 5'b0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [10:0] a,
                        input logic e1, input logic e2, input logic [31:0] ed,
                        input string tag);
        rst  = r;
        read = rd;
        addr = a;
        @(posedge clk);
        #1;
        $display("%s rst=%0b read=%0b addr=0x%03h -> l1=%0b l2=%0b data=0x%08h",
                 tag, r, rd, a, l1_hit, l2_hit, read_data);
        check({tag, " l1_hit"}, {31'b0, l1_hit}, {31'b0, e1});
        check({tag, " l2_hit"}, {31'b0, l2_hit}, {31'b0, e2});
        check({tag, " read_data"}, read_data, ed);
        check({tag, " hit_excl"}, {31'b0, l1_hit & l2_hit}, 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        read = 1'b0;
        addr = '0;

        vecs[0]  = '{1'b1, 1'b0, 11'h000, 1'b0, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b1, 11'h020, 1'b0, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b1, 11'h020, 1'b0, 1'b0, 32'h0020_0020};
        vecs[3]  = '{1'b0, 1'b1, 11'h020, 1'b1, 1'b0, 32'h0020_0020};
        vecs[4]  = '{1'b0, 1'b1, 11'h040, 1'b0, 1'b0, 32'h0040_0040};
        vecs[5]  = '{1'b0, 1'b1, 11'h020, 1'b1, 1'b0, 32'h0020_0020};
        vecs[6]  = '{1'b0, 1'b1, 11'h060, 1'b0, 1'b0, 32'h0060_0060};
        vecs[7]  = '{1'b0, 1'b1, 11'h040, 1'b0, L2_ON, 32'h0040_0040};
        vecs[8]  = '{1'b0, 1'b1, 11'h060, 1'b1, 1'b0, 32'h0060_0060};
        vecs[9]  = '{1'b0, 1'b0, 11'h060, 1'b0, 1'b0, 32'h0060_0060};
        vecs[10] = '{1'b0, 1'b0, 11'h7ff, 1'b0, 1'b0, 32'h0060_0060};
        vecs[11] = '{1'b0, 1'b1, 11'h040, 1'b1, 1'b0, 32'h0040_0040};
        vecs[12] = '{1'b0, 1'b1, 11'h7ff, 1'b0, 1'b0, 32'h07ff_07ff};
        vecs[13] = '{1'b0, 1'b1, 11'h7ff, 1'b1, 1'b0, 32'h07ff_07ff};
        vecs[14] = '{1'b0, 1'b1, 11'h020, 1'b0, 1'b0, 32'h0020_0020};
        vecs[15] = '{1'b0, 1'b1, 11'h060, 1'b0, 1'b0, 32'h0060_0060};
        vecs[16] = '{1'b0, 1'b1, 11'h040, 1'b0, L2_ON, 32'h0040_0040};
        vecs[17] = '{1'b1, 1'b0, 11'h000, 1'b0, 1'b0, 32'h0000_0000};
        vecs[18] = '{1'b0, 1'b1, 11'h040, 1'b0, 1'b0, 32'h0040_0040};
        vecs[19] = '{1'b0, 1'b1, 11'h7ff, 1'b0, 1'b0, 32'h07ff_07ff};
        vecs[20] = '{1'b1, 1'b1, 11'h040, 1'b0, 1'b0, 32'h0000_0000};
        vecs[21] = '{1'b0, 1'b1, 11'h040, 1'b0, 1'b0, 32'h0040_0040};

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].read, vecs[i].addr,
                 vecs[i].exp_l1, vecs[i].exp_l2, vecs[i].exp_data,
                 $sformatf("vec%0d", i));
        end

        // Back-to-back fills across every set, then back-to-back hits.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 11'h100 + 11'(i), 1'b0, 1'b0, ref_word(11'h100 + 11'(i)),
                 $sformatf("fill%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 11'h100 + 11'(i), 1'b1, 1'b0, ref_word(11'h100 + 11'(i)),
                 $sformatf("rehit%0d", i));
        end

        // Both set-0 residents survive: 0x040 (way 0) and 0x100 (way 1).
        step(1'b0, 1'b1, 11'h040, 1'b1, 1'b0, 32'h0040_0040, "keep040");
        step(1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 32'h0040_0040, "idle");

        read = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
